// File: rtl/rr_session_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_session_mux_if
//  Description : Bundle of grant, per-requester streams and the shared output
//                stream around rr_session_mux. The slave modport is the mux
//                side. The master modport is the arbiter/requester/sink side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_session_mux_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        grant;
    logic                    session_is_finished;
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ*DATA_W-1:0] in_data;
    logic [N_REQ-1:0]        in_last;
    logic [N_REQ-1:0]        in_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;
    logic [SRC_W-1:0]        out_src;
    logic                    err_grant;
    logic                    err_timeout;

    modport slave (
        input  grant, in_valid, in_data, in_last, out_ready,
        output session_is_finished, in_ready, out_valid, out_data, out_last,
               out_src, err_grant, err_timeout
    );

    modport master (
        output grant, in_valid, in_data, in_last, out_ready,
        input  session_is_finished, in_ready, out_valid, out_data, out_last,
               out_src, err_grant, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_session_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_session_mux
//  Description : Latches the one-hot grant of a round-robin arbiter and routes
//                the winning requester's valid/ready/data/last stream onto a
//                single shared output. The session ends on last beat, on the
//                MAX_BEATS-th beat, or on an idle timeout. The end of a session
//                is reported back to the arbiter as a one-cycle finish pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_session_mux #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int IDLE_TMO  = 64
) (
    input  logic            clk,
    input  logic            rst_an,
    rr_session_mux_if.slave bus
);
    localparam int SRC_W  = (N_REQ > 1)     ? $clog2(N_REQ)     : 1;
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int TMO_W  = (IDLE_TMO > 1)  ? $clog2(IDLE_TMO)  : 1;
    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(IDLE_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_grant_q, err_grant_d;
    logic              err_tmo_q, err_tmo_d;

    logic [SRC_W-1:0]  w_grant_idx;
    logic              w_grant_onehot;
    logic              w_grant_any;
    logic              w_xfer;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_out_last;
    logic              w_hs;

    // Encode the grant vector to an index and classify it as one-hot or not.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.grant[i]) begin
                w_grant_idx = i[SRC_W-1:0];
            end
        end
        w_grant_any    = |bus.grant;
        w_grant_onehot = w_grant_any &&
                         ((bus.grant & (bus.grant - N_REQ'(1))) == '0);
    end

    // Select the latched requester's stream.
    always_comb begin
        w_sel_valid = bus.in_valid[src_q];
        w_sel_last  = bus.in_last[src_q];
        w_sel_data  = bus.in_data[int'(src_q)*DATA_W +: DATA_W];
    end

    // The shared port is a pure pass-through, so it is only live while in XFER.
    assign w_xfer     = (state_q == S_XFER);
    assign w_out_last = w_sel_last | (beat_q == C_BEAT_LAST);
    assign w_hs       = w_xfer & w_sel_valid & bus.out_ready;

    assign bus.out_valid           = w_xfer & w_sel_valid;
    assign bus.out_data            = w_xfer ? w_sel_data : '0;
    assign bus.out_last            = w_xfer & w_out_last;
    assign bus.in_ready            = w_xfer ? (N_REQ'(bus.out_ready) << src_q) : '0;
    assign bus.out_src             = src_q;
    assign bus.session_is_finished = (state_q == S_FIN);
    assign bus.err_grant           = err_grant_q;
    assign bus.err_timeout         = err_tmo_q;

    // Session sequencing: latch grant, count beats and idle cycles, finish.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        err_grant_d = 1'b0;
        err_tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_grant_onehot) begin
                    src_d   = w_grant_idx;
                    beat_d  = '0;
                    tmo_d   = '0;
                    state_d = S_XFER;
                end else if (w_grant_any) begin
                    err_grant_d = 1'b1;
                end
            end
            S_XFER: begin
                if (w_hs) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (w_out_last) begin
                        state_d = S_FIN;
                    end
                end
                // A valid beat (accepted or stalled) restarts the idle window;
                // the timeout error coincides with the finish pulse.
                if (w_sel_valid) begin
                    tmo_d = '0;
                end else if (tmo_q == C_TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any session without a finish.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            err_grant_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            err_grant_q <= err_grant_d;
            err_tmo_q   <= err_tmo_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rr_session_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_session_mux
//  Description : Directed self-checking bench for rr_session_mux.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_session_mux;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;

    logic clk;
    logic rst_an;
    int   vecs;
    int   errs;

    rr_session_mux_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    rr_session_mux #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BEATS(16), .IDLE_TMO(64)
    ) dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] data_of(input int r, input int b);
        return 32'hD000_0000 | (r << 8) | b;
    endfunction

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_an = 1'b0;
        bus.grant = 4'b0001; bus.in_valid = 4'b1111; bus.in_last = 4'b1111;
        bus.out_ready = 1'b1; bus.in_data = {4{32'hFFFF_FFFF}};
        @(negedge clk);
        vecs++; if (bus.session_is_finished !== 1'b0) begin errs++; $display("FAIL rst_fin got %b exp 0", bus.session_is_finished); end
        vecs++; if (bus.in_ready !== 4'b0000) begin errs++; $display("FAIL rst_in_ready got %b exp 0000", bus.in_ready); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        vecs++; if (bus.out_data !== 32'h0) begin errs++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
        vecs++; if (bus.out_last !== 1'b0) begin errs++; $display("FAIL rst_out_last got %b exp 0", bus.out_last); end
        vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL rst_out_src got %0d exp 0", bus.out_src); end
        vecs++; if ({bus.err_grant, bus.err_timeout} !== 2'b00) begin errs++; $display("FAIL rst_err got %b exp 00", {bus.err_grant, bus.err_timeout}); end
        bus.grant = '0; bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0;
        step();
        rst_an = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus.grant = 4'b0001;
        step();
        bus.grant = '0; bus.out_ready = 1'b1; bus.in_valid = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            bus.in_data[0 +: 32] = data_of(0, b);
            bus.in_last[0] = (b == 2);
            @(negedge clk);
            vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid b%0d got %b exp 1", b, bus.out_valid); end
            vecs++; if (bus.out_data !== data_of(0, b)) begin errs++; $display("FAIL basic_data b%0d got %h exp %h", b, bus.out_data, data_of(0, b)); end
            vecs++; if (bus.out_last !== (b == 2)) begin errs++; $display("FAIL basic_last b%0d got %b exp %b", b, bus.out_last, (b == 2)); end
            vecs++; if (bus.in_ready !== 4'b0001) begin errs++; $display("FAIL basic_in_ready b%0d got %b exp 0001", b, bus.in_ready); end
            vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL basic_src b%0d got %0d exp 0", b, bus.out_src); end
            vecs++; if (bus.session_is_finished !== 1'b0) begin errs++; $display("FAIL basic_early_fin b%0d got 1 exp 0", b); end
            step();
        end
        bus.in_valid = '0; bus.in_last = '0;
        @(negedge clk);
        vecs++; if ({bus.session_is_finished, bus.out_valid, bus.in_ready} !== 6'b100000) begin errs++; $display("FAIL basic_fin got %b exp 100000", {bus.session_is_finished, bus.out_valid, bus.in_ready}); end
        step();
        @(negedge clk);
        vecs++; if ({bus.session_is_finished, bus.in_ready} !== 5'b00000) begin errs++; $display("FAIL basic_idle got %b exp 00000", {bus.session_is_finished, bus.in_ready}); end
        step();
    endtask

    task automatic test_grant_ignored();
        bus.grant = 4'b0001;
        step();
        bus.grant = 4'b0100; bus.in_valid = 4'b0101; bus.out_ready = 1'b1;
        bus.in_data[64 +: 32] = 32'hBAD0_0002;
        for (int b = 0; b < 2; b++) begin
            bus.in_data[0 +: 32] = data_of(0, b);
            bus.in_last[0] = (b == 1);
            @(negedge clk);
            vecs++; if (bus.in_ready !== 4'b0001) begin errs++; $display("FAIL ign_in_ready b%0d got %b exp 0001", b, bus.in_ready); end
            vecs++; if (bus.out_src !== 2'd0) begin errs++; $display("FAIL ign_src b%0d got %0d exp 0", b, bus.out_src); end
            vecs++; if (bus.out_data !== data_of(0, b)) begin errs++; $display("FAIL ign_data b%0d got %h exp %h", b, bus.out_data, data_of(0, b)); end
            step();
        end
        bus.grant = '0; bus.in_valid = '0; bus.in_last = '0;
        @(negedge clk);
        vecs++; if (bus.session_is_finished !== 1'b1) begin errs++; $display("FAIL ign_fin got %b exp 1", bus.session_is_finished); end
        step();
        step();
    endtask

    task automatic test_max_beats();
        int beat;
        logic stall;
        beat = 0;
        bus.grant = 4'b0010;
        step();
        bus.grant = '0; bus.in_valid = 4'b0010; bus.in_last = '0;
        for (int c = 0; c < 17; c++) begin
            stall = (c == 5);
            bus.out_ready = !stall;
            bus.in_data[32 +: 32] = data_of(1, beat);
            @(negedge clk);
            vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL max_valid c%0d got %b exp 1", c, bus.out_valid); end
            vecs++; if (bus.out_data !== data_of(1, beat)) begin errs++; $display("FAIL max_data c%0d got %h exp %h", c, bus.out_data, data_of(1, beat)); end
            vecs++; if (bus.out_last !== (beat == 15)) begin errs++; $display("FAIL max_last c%0d beat%0d got %b exp %b", c, beat, bus.out_last, (beat == 15)); end
            vecs++; if (bus.in_ready !== (stall ? 4'b0000 : 4'b0010)) begin errs++; $display("FAIL max_in_ready c%0d got %b exp %b", c, bus.in_ready, (stall ? 4'b0000 : 4'b0010)); end
            step();
            if (!stall) beat++;
        end
        bus.out_ready = 1'b1;
        bus.in_data[32 +: 32] = data_of(1, beat);
        @(negedge clk);
        vecs++; if ({bus.session_is_finished, bus.out_valid, bus.in_ready} !== 6'b100000) begin errs++; $display("FAIL max_beat17 got %b exp 100000", {bus.session_is_finished, bus.out_valid, bus.in_ready}); end
        step();
        @(negedge clk);
        vecs++; if ({bus.session_is_finished, bus.in_ready} !== 5'b00000) begin errs++; $display("FAIL max_idle got %b exp 00000", {bus.session_is_finished, bus.in_ready}); end
        bus.in_valid = '0;
        step();
    endtask

    task automatic test_timeout();
        bus.grant = 4'b1000;
        step();
        bus.grant = '0; bus.out_ready = 1'b0;
        // one stalled valid at c=40 restarts the idle window
        for (int c = 0; c < 105; c++) begin
            bus.in_valid = (c == 40) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            vecs++; if ({bus.out_valid, bus.err_timeout, bus.session_is_finished} !== {(c == 40), 2'b00}) begin errs++; $display("FAIL tmo_wait c%0d got %b exp %b", c, {bus.out_valid, bus.err_timeout, bus.session_is_finished}, {(c == 40), 2'b00}); end
            step();
        end
        bus.in_valid = '0; bus.out_ready = 1'b1;
        @(negedge clk);
        vecs++; if ({bus.err_timeout, bus.session_is_finished, bus.out_valid} !== 3'b110) begin errs++; $display("FAIL tmo_fire got %b exp 110", {bus.err_timeout, bus.session_is_finished, bus.out_valid}); end
        step();
        @(negedge clk);
        vecs++; if ({bus.err_timeout, bus.session_is_finished} !== 2'b00) begin errs++; $display("FAIL tmo_after got %b exp 00", {bus.err_timeout, bus.session_is_finished}); end
        step();
    endtask

    task automatic test_bad_grant();
        bus.grant = 4'b0110; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        vecs++; if (bus.err_grant !== 1'b1) begin errs++; $display("FAIL bad_err got %b exp 1", bus.err_grant); end
        vecs++; if ({bus.in_ready, bus.out_valid, bus.session_is_finished} !== 6'b000000) begin errs++; $display("FAIL bad_outs got %b exp 000000", {bus.in_ready, bus.out_valid, bus.session_is_finished}); end
        bus.grant = '0;
        step();
        @(negedge clk);
        vecs++; if ({bus.err_grant, bus.in_ready, bus.out_valid} !== 6'b000000) begin errs++; $display("FAIL bad_after got %b exp 000000", {bus.err_grant, bus.in_ready, bus.out_valid}); end
        bus.in_valid = '0;
        step();
    endtask

    task automatic test_back_to_back();
        bus.grant = 4'b0001;
        step();
        bus.grant = '0; bus.out_ready = 1'b1; bus.in_valid = 4'b0001; bus.in_last = 4'b0001;
        bus.in_data[0 +: 32] = data_of(0, 7);
        @(negedge clk);
        vecs++; if ({bus.out_valid, bus.out_last} !== 2'b11) begin errs++; $display("FAIL b2b_single got %b exp 11", {bus.out_valid, bus.out_last}); end
        step();
        bus.in_valid = '0; bus.in_last = '0;
        @(negedge clk);
        vecs++; if (bus.session_is_finished !== 1'b1) begin errs++; $display("FAIL b2b_fin0 got %b exp 1", bus.session_is_finished); end
        step();
        bus.grant = 4'b0010; bus.in_valid = 4'b0010; bus.in_last = 4'b0010;
        bus.in_data[32 +: 32] = data_of(1, 0);
        @(negedge clk);
        vecs++; if ({bus.session_is_finished, bus.out_valid, bus.in_ready} !== 6'b000000) begin errs++; $display("FAIL b2b_idle got %b exp 000000", {bus.session_is_finished, bus.out_valid, bus.in_ready}); end
        step();
        bus.grant = '0;
        @(negedge clk);
        vecs++; if ({bus.out_src, bus.out_valid, bus.in_ready} !== 7'b01_1_0010) begin errs++; $display("FAIL b2b_xfer1 got %b exp 0110010", {bus.out_src, bus.out_valid, bus.in_ready}); end
        vecs++; if (bus.out_data !== data_of(1, 0)) begin errs++; $display("FAIL b2b_data1 got %h exp %h", bus.out_data, data_of(1, 0)); end
        step();
        bus.in_valid = '0; bus.in_last = '0;
        @(negedge clk);
        vecs++; if (bus.session_is_finished !== 1'b1) begin errs++; $display("FAIL b2b_fin1 got %b exp 1", bus.session_is_finished); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.grant = 4'b0100;
        step();
        bus.grant = '0; bus.out_ready = 1'b1; bus.in_valid = 4'b0100;
        bus.in_data[64 +: 32] = data_of(2, 0);
        @(negedge clk);
        vecs++; if ({bus.out_src, bus.out_valid} !== 3'b10_1) begin errs++; $display("FAIL mid_pre got %b exp 101", {bus.out_src, bus.out_valid}); end
        step();
        bus.in_data[64 +: 32] = data_of(2, 1);
        #2 rst_an = 1'b0;
        #1;
        vecs++; if ({bus.out_valid, bus.out_last, bus.in_ready, bus.out_src, bus.session_is_finished} !== 9'b0) begin errs++; $display("FAIL mid_async got %b exp 000000000", {bus.out_valid, bus.out_last, bus.in_ready, bus.out_src, bus.session_is_finished}); end
        vecs++; if (bus.out_data !== 32'h0) begin errs++; $display("FAIL mid_data got %h exp 0", bus.out_data); end
        @(posedge clk);
        #1 rst_an = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++; if ({bus.session_is_finished, bus.out_valid, bus.in_ready} !== 6'b0) begin errs++; $display("FAIL mid_after c%0d got %b exp 000000", c, {bus.session_is_finished, bus.out_valid, bus.in_ready}); end
            step();
        end
        bus.in_valid = '0;
        step();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_an = 1'b0;
        bus.grant = '0; bus.in_valid = '0; bus.in_data = '0;
        bus.in_last = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_grant_ignored();
        test_max_beats();
        test_timeout();
        test_bad_grant();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire
